engine_scheduler: RTL

Shares the single FFT engine and the single FIR engine between NREQ host-side requesters, such as receive-channel front ends. Requesters submit jobs tagged with a mode; only one job runs at a time across both engines. The block grants jobs round-robin, pulses the matching engine start, and watches for done with a timeout. It then holds ownership until the requester releases the result buffer. It sits between the host interface logic and the fft/fir datapaths, and replaces ad-hoc start sequencing in the core.

---
 rtl/sched_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/engine_scheduler.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/sched_pkg.sv
// Shared types and helpers for the FFT/FIR engine scheduler.
package sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } sched_state_t;

    localparam logic [1:0] MODE_FFT = 2'b00;
    localparam logic [1:0] MODE_FIR = 2'b01;

    function automatic logic mode_legal(input logic [1:0] mode);
        return (mode == MODE_FFT) || (mode == MODE_FIR);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after the pointer, wrapping.
module rr_arbiter
    import sched_pkg::*;
#(
    parameter  int NREQ    = 2,
    localparam int OWNER_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]    i_req,
    input  logic [OWNER_W-1:0] i_ptr,
    output logic [OWNER_W-1:0] o_win,
    output logic               o_any
);

    int w_idx;

    always_comb begin
        o_any = 1'b0;
        o_win = '0;
        w_idx = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = int'(i_ptr) + k;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (!o_any && i_req[w_idx[OWNER_W-1:0]]) begin
                o_any = 1'b1;
                o_win = w_idx[OWNER_W-1:0];
            end
        end
    end

endmodule

// File: rtl/engine_scheduler.sv
// Round-robin owner of the shared FFT/FIR engines: grant, start, done/timeout watch, result hold.
// Define SCHED_STATS_EN to add saturating job statistics counters.
module engine_scheduler
    import sched_pkg::*;
#(
    parameter  int NREQ           = 2,
    parameter  int TIMEOUT_CYCLES = 4096,
    localparam int OWNER_W        = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [2*NREQ-1:0]    req_mode,
    output logic [NREQ-1:0]      req_grant,
    output logic [NREQ-1:0]      job_done,
    output logic [NREQ-1:0]      job_err,
    input  logic [NREQ-1:0]      job_release,
    output logic                 fft_start,
    output logic                 fir_start,
    input  logic                 fft_done,
    input  logic                 fir_done,
    output logic                 engine_abort,
    output logic                 busy,
    output logic [OWNER_W-1:0]   owner
`ifdef SCHED_STATS_EN
    ,
    input  logic                 stat_clr,
    output logic [15:0]          stat_fft_jobs,
    output logic [15:0]          stat_fir_jobs,
    output logic [15:0]          stat_err_jobs
`endif
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    sched_state_t       r_state, w_state_nxt;
    logic [OWNER_W-1:0] r_ptr, w_ptr_nxt;
    logic [OWNER_W-1:0] r_owner, w_owner_nxt;
    logic [1:0]         r_mode, w_mode_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [NREQ-1:0]    r_grant, r_done, r_err;
    logic [NREQ-1:0]    w_grant_nxt, w_done_nxt, w_err_nxt;
    logic               r_fft_start, r_fir_start, r_abort, r_busy;
    logic               w_fft_nxt, w_fir_nxt, w_abort_nxt;

    logic               w_any;
    logic [OWNER_W-1:0] w_win;
    logic [1:0]         w_win_mode;
    logic [NREQ-1:0]    w_win_oh, w_owner_oh;
    logic [OWNER_W-1:0] w_win_inc, w_owner_inc;
    logic               w_take, w_legal, w_eng_done, w_timeout, w_release;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_win (w_win),
        .o_any (w_any)
    );

    always_comb begin
        w_win_mode = MODE_FFT;
        w_win_oh   = '0;
        w_owner_oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == OWNER_W'(i)) begin
                w_win_mode  = req_mode[2*i +: 2];
                w_win_oh[i] = 1'b1;
            end
            if (r_owner == OWNER_W'(i)) begin
                w_owner_oh[i] = 1'b1;
            end
        end
    end

    assign w_win_inc   = (w_win == OWNER_W'(NREQ - 1)) ? '0 : w_win + 1'b1;
    assign w_owner_inc = (r_owner == OWNER_W'(NREQ - 1)) ? '0 : r_owner + 1'b1;
    // The cycle right after any grant is never a grant cycle, keeping a one-cycle gap.
    assign w_take      = (r_state == IDLE) && w_any && (r_grant == '0);
    assign w_legal     = mode_legal(w_win_mode);
    assign w_eng_done  = (r_mode == MODE_FFT) ? fft_done : fir_done;
    assign w_timeout   = (r_cnt == CNT_LAST);
    assign w_release   = |(job_release & w_owner_oh);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_take && w_legal) w_state_nxt = RUN;
            RUN: begin
                if (w_eng_done) begin
                    w_state_nxt = HOLD;
                end else if (w_timeout) begin
                    w_state_nxt = IDLE;
                end
            end
            HOLD:    if (w_release) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_grant_nxt = '0;
        w_done_nxt  = '0;
        w_err_nxt   = '0;
        w_fft_nxt   = 1'b0;
        w_fir_nxt   = 1'b0;
        w_abort_nxt = 1'b0;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_mode_nxt  = r_mode;
        w_cnt_nxt   = '0;
        case (r_state)
            IDLE: begin
                if (w_take) begin
                    w_grant_nxt = w_win_oh;
                    if (w_legal) begin
                        w_owner_nxt = w_win;
                        w_mode_nxt  = w_win_mode;
                        w_fft_nxt   = (w_win_mode == MODE_FFT);
                        w_fir_nxt   = (w_win_mode == MODE_FIR);
                    end else begin
                        w_err_nxt = w_win_oh;
                        w_ptr_nxt = w_win_inc;
                    end
                end
            end
            RUN: begin
                // Done takes priority over a timeout landing in the same cycle.
                if (w_eng_done) begin
                    w_done_nxt = w_owner_oh;
                end else if (w_timeout) begin
                    w_abort_nxt = 1'b1;
                    w_err_nxt   = w_owner_oh;
                    w_ptr_nxt   = w_owner_inc;
                    w_owner_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            HOLD: begin
                if (w_release) begin
                    w_ptr_nxt   = w_owner_inc;
                    w_owner_nxt = '0;
                end
            end
            default: begin
                w_owner_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_ptr       <= '0;
            r_owner     <= '0;
            r_mode      <= MODE_FFT;
            r_cnt       <= '0;
            r_grant     <= '0;
            r_done      <= '0;
            r_err       <= '0;
            r_fft_start <= 1'b0;
            r_fir_start <= 1'b0;
            r_abort     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_ptr       <= w_ptr_nxt;
            r_owner     <= w_owner_nxt;
            r_mode      <= w_mode_nxt;
            r_cnt       <= w_cnt_nxt;
            r_grant     <= w_grant_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_fft_start <= w_fft_nxt;
            r_fir_start <= w_fir_nxt;
            r_abort     <= w_abort_nxt;
            r_busy      <= (w_state_nxt != IDLE);
        end
    end

    assign req_grant    = r_grant;
    assign job_done     = r_done;
    assign job_err      = r_err;
    assign fft_start    = r_fft_start;
    assign fir_start    = r_fir_start;
    assign engine_abort = r_abort;
    assign busy         = r_busy;
    assign owner        = r_owner;

`ifdef SCHED_STATS_EN
    logic [15:0] r_stat_fft, r_stat_fir, r_stat_err;
    logic        w_fft_evt, w_fir_evt, w_err_evt;

    assign w_fft_evt = (r_state == RUN) && w_eng_done && (r_mode == MODE_FFT);
    assign w_fir_evt = (r_state == RUN) && w_eng_done && (r_mode == MODE_FIR);
    assign w_err_evt = |w_err_nxt;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_stat_fft <= '0;
            r_stat_fir <= '0;
            r_stat_err <= '0;
        end else if (stat_clr) begin
            r_stat_fft <= '0;
            r_stat_fir <= '0;
            r_stat_err <= '0;
        end else begin
            if (w_fft_evt && (r_stat_fft != 16'hFFFF)) r_stat_fft <= r_stat_fft + 16'd1;
            if (w_fir_evt && (r_stat_fir != 16'hFFFF)) r_stat_fir <= r_stat_fir + 16'd1;
            if (w_err_evt && (r_stat_err != 16'hFFFF)) r_stat_err <= r_stat_err + 16'd1;
        end
    end

    assign stat_fft_jobs = r_stat_fft;
    assign stat_fir_jobs = r_stat_fir;
    assign stat_err_jobs = r_stat_err;
`endif

endmodule
